// File: rtl/mem_stage.sv
// Purpose : MEM stage of the pipeline; issues data-memory accesses, registers MEM/WB.
// Latency : 1 cycle for ALU, bubble and misaligned ops; 2+N cycles for memory ops (N = ack wait cycles).
// Backpr. : stall holds all upstream pipeline registers while an aligned access is outstanding.
//
// Ports
//   clock, reset            single clock, synchronous active-low reset
//   i*  (EX/MEM)            instruction, PC, PC+4, branch target, control bits, ALU result,
//                           store data, destination register, valid
//   dmem_*                  data-memory request/write-enable/address/write-data out,
//                           read-data and one-cycle ack in
//   stall                   freeze request to the upstream pipeline registers
//   redirect, oTargetPC     taken branch/jump and its target
//   o*  (MEM/WB)            registered control, status and data for write-back
module mem_stage (
  input  logic        clock,
  input  logic        reset,

  input  logic [31:0] iInstr,
  input  logic [31:0] iPC,
  input  logic [31:0] iNPC1,
  input  logic [31:0] inextPCBranch,
  input  logic        iRegWrite,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iMemToReg,
  input  logic        iBranch,
  input  logic        iinvertzero,
  input  logic        iJump,
  input  logic        iZero,
  input  logic [31:0] iResult,
  input  logic [31:0] iB,
  input  logic [4:0]  iwriteRegWire,
  input  logic        ivalid,

  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,

  output logic        stall,
  output logic        redirect,
  output logic [31:0] oTargetPC,

  output logic        oRegWrite,
  output logic        oMemToReg,
  output logic        ovalid,
  output logic        oAddrErr,
  output logic [31:0] oReadData,
  output logic [31:0] oResult,
  output logic [31:0] oInstr,
  output logic [31:0] oPC,
  output logic [4:0]  owriteRegWire
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } stateT;

  // What the MEM/WB register loads on the coming edge.
  typedef enum logic [1:0] {
    WB_PASS    = 2'd0,  // non-memory or invalid entry straight from EX/MEM
    WB_BUBBLE  = 2'd1,  // access not finished yet
    WB_DONE    = 2'd2,  // access acknowledged this cycle
    WB_ADDRERR = 2'd3   // misaligned memory op, reported without touching memory
  } wbSelT;

  // EX/MEM fields captured when an access starts. Upstream may release its
  // registers on the ack cycle, so completion must not depend on live inputs.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] storeData;
    logic [4:0]  writeReg;
    logic        regWrite;
    logic        memToReg;
    logic        memWrite;
  } memFieldsT;

  stateT     state;
  stateT     nextState;
  wbSelT     wbSel;
  logic      latchEn;
  logic      memOp;
  logic      misaligned;
  memFieldsT inFields;
  memFieldsT held;

  // Only the region bits of PC+4 feed the jump target.
  logic      unusedNpcBits;
  assign unusedNpcBits = ^iNPC1[27:0];

  assign memOp      = ivalid & (iMemRead | iMemWrite);
  assign misaligned = (iResult[1:0] != 2'b00);

  always_comb begin
    inFields           = '0;
    inFields.instr     = iInstr;
    inFields.pc        = iPC;
    inFields.result    = iResult;
    inFields.storeData = iB;
    inFields.writeReg  = iwriteRegWire;
    inFields.regWrite  = iRegWrite;
    inFields.memToReg  = iMemToReg;
    inFields.memWrite  = iMemWrite;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (memOp && !misaligned) begin
          nextState = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    stall    = 1'b0;
    dmem_req = 1'b0;
    latchEn  = 1'b0;
    wbSel    = WB_PASS;
    case (state)
      IDLE: begin
        // dmem_ack is deliberately not looked at here.
        if (memOp) begin
          if (misaligned) begin
            wbSel = WB_ADDRERR;
          end else begin
            // Hold EX/MEM for the capture edge; nothing retires yet.
            stall   = 1'b1;
            latchEn = 1'b1;
            wbSel   = WB_BUBBLE;
          end
        end
      end
      ACCESS: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          // Release upstream in the same cycle so the pipe advances on this edge.
          wbSel = WB_DONE;
        end else begin
          stall = 1'b1;
          wbSel = WB_BUBBLE;
        end
      end
      default: begin
        stall    = 1'b0;
        dmem_req = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access capture: address and store data stay put until the ack.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      held <= '0;
    end else if (latchEn) begin
      held <= inFields;
    end
  end

  assign dmem_addr  = held.result;
  assign dmem_wdata = held.storeData;
  assign dmem_we    = dmem_req & held.memWrite;

  // ---------------------------------------------------------------------------
  // Control transfer resolution, straight from EX/MEM.
  // ---------------------------------------------------------------------------
  assign redirect  = ivalid & ~stall & ((iBranch & (iZero ^ iinvertzero)) | iJump);
  assign oTargetPC = iJump ? {iNPC1[31:28], iInstr[25:0], 2'b00} : inextPCBranch;

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      oRegWrite     <= 1'b0;
      oMemToReg     <= 1'b0;
      ovalid        <= 1'b0;
      oAddrErr      <= 1'b0;
      oReadData     <= '0;
      oResult       <= '0;
      oInstr        <= '0;
      oPC           <= '0;
      owriteRegWire <= '0;
    end else begin
      case (wbSel)
        WB_PASS: begin
          oInstr        <= iInstr;
          oPC           <= iPC;
          oResult       <= iResult;
          owriteRegWire <= iwriteRegWire;
          oMemToReg     <= iMemToReg;
          // An invalid entry must never write the register file.
          oRegWrite     <= ivalid & iRegWrite;
          ovalid        <= ivalid;
          oAddrErr      <= 1'b0;
          oReadData     <= '0;
        end
        WB_ADDRERR: begin
          oInstr        <= iInstr;
          oPC           <= iPC;
          oResult       <= iResult;
          owriteRegWire <= iwriteRegWire;
          oMemToReg     <= iMemToReg;
          oRegWrite     <= 1'b0;
          ovalid        <= 1'b1;
          oAddrErr      <= 1'b1;
          oReadData     <= '0;
        end
        WB_DONE: begin
          oInstr        <= held.instr;
          oPC           <= held.pc;
          oResult       <= held.result;
          owriteRegWire <= held.writeReg;
          oMemToReg     <= held.memToReg;
          oRegWrite     <= held.regWrite;
          ovalid        <= 1'b1;
          oAddrErr      <= 1'b0;
          oReadData     <= held.memWrite ? 32'd0 : dmem_rdata;
        end
        default: begin
          // Bubble: data fields keep their old contents, only the
          // qualifiers are cleared.
          ovalid        <= 1'b0;
          oRegWrite     <= 1'b0;
          oAddrErr      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : self-checking bench for mem_stage; directed cases plus random instruction stream.
// Latency : n/a (bench).
// Backpr. : bench acts as the upstream stage and holds its EX/MEM values while stall is high.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iInstr, iPC, iNPC1, inextPCBranch, iResult, iB;
  logic        iRegWrite, iMemRead, iMemWrite, iMemToReg, iBranch, iinvertzero, iJump, iZero;
  logic [4:0]  iwriteRegWire;
  logic        ivalid;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, redirect;
  logic [31:0] oTargetPC;
  logic        oRegWrite, oMemToReg, ovalid, oAddrErr;
  logic [31:0] oReadData, oResult, oInstr, oPC;
  logic [4:0]  owriteRegWire;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_stage dut (
    .clock(clock), .reset(reset),
    .iInstr(iInstr), .iPC(iPC), .iNPC1(iNPC1), .inextPCBranch(inextPCBranch),
    .iRegWrite(iRegWrite), .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
    .iBranch(iBranch), .iinvertzero(iinvertzero), .iJump(iJump), .iZero(iZero),
    .iResult(iResult), .iB(iB), .iwriteRegWire(iwriteRegWire), .ivalid(ivalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .redirect(redirect), .oTargetPC(oTargetPC),
    .oRegWrite(oRegWrite), .oMemToReg(oMemToReg), .ovalid(ovalid), .oAddrErr(oAddrErr),
    .oReadData(oReadData), .oResult(oResult), .oInstr(oInstr), .oPC(oPC),
    .owriteRegWire(owriteRegWire)
  );

  typedef struct {
    logic [31:0] instr, pc, npc, tgt, result, b;
    logic [4:0]  wr;
    logic        regWrite, memRead, memWrite, memToReg, branch, inv, jump, zero, valid;
  } instT;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // kind: 0 invalid, 1 ALU, 2 aligned load, 3 aligned store, 4 misaligned memory op
  function automatic instT randInst(input int kind);
    instT t;
    t.instr    = $urandom;
    t.pc       = $urandom;
    t.npc      = $urandom;
    t.tgt      = $urandom;
    t.b        = $urandom;
    t.result   = $urandom;
    t.wr       = 5'($urandom_range(0, 31));
    t.regWrite = 1'($urandom_range(0, 1));
    t.memToReg = 1'($urandom_range(0, 1));
    t.branch   = 1'($urandom_range(0, 1));
    t.inv      = 1'($urandom_range(0, 1));
    t.jump     = 1'($urandom_range(0, 1));
    t.zero     = 1'($urandom_range(0, 1));
    t.valid    = 1'b1;
    t.memRead  = 1'b0;
    t.memWrite = 1'b0;
    case (kind)
      0: begin
        t.valid    = 1'b0;
        t.memRead  = 1'($urandom_range(0, 1));
        t.memWrite = 1'($urandom_range(0, 1));
      end
      2: begin
        t.memRead   = 1'b1;
        t.result[1:0] = 2'b00;
      end
      3: begin
        t.memWrite  = 1'b1;
        t.regWrite  = 1'b0;
        t.result[1:0] = 2'b00;
      end
      4: begin
        t.memRead   = 1'($urandom_range(0, 1));
        t.memWrite  = ~t.memRead;
        t.result[1:0] = 2'($urandom_range(1, 3));
      end
      default: ;
    endcase
    return t;
  endfunction

  task automatic drive(input instT t);
    iInstr = t.instr; iPC = t.pc; iNPC1 = t.npc; inextPCBranch = t.tgt;
    iResult = t.result; iB = t.b; iwriteRegWire = t.wr;
    iRegWrite = t.regWrite; iMemRead = t.memRead; iMemWrite = t.memWrite;
    iMemToReg = t.memToReg; iBranch = t.branch; iinvertzero = t.inv;
    iJump = t.jump; iZero = t.zero; ivalid = t.valid;
  endtask

  // Present one instruction (called just after a falling edge), act as the
  // memory with the given number of wait cycles, and check the retired result
  // against what the instruction should produce.
  task automatic runInstr(input instT t, input int delay, input logic [31:0] rdata,
                          input logic idleAck);
    logic        isMem, isMis, isAccess, xfer, ack;
    logic [31:0] expTgt, expRd;
    int          stallCount;
    isMem    = t.valid & (t.memRead | t.memWrite);
    isMis    = (t.result % 4) != 0;
    isAccess = isMem & ~isMis;
    xfer     = (t.branch & (t.zero ^ t.inv)) | t.jump;
    expTgt   = t.jump ? {t.npc[31:28], t.instr[25:0], 2'b00} : t.tgt;
    expRd    = (isAccess && !t.memWrite) ? rdata : 32'd0;
    stallCount = 0;

    drive(t);
    dmem_ack   = idleAck;
    dmem_rdata = $urandom;
    #1;
    chk1("stall_first", stall, isAccess);
    chk1("req_first", dmem_req, 1'b0);
    chk1("redirect_first", redirect, t.valid & ~isAccess & xfer);
    chk32("target", oTargetPC, expTgt);
    if (stall) stallCount++;

    if (isAccess) begin
      for (int w = 0; w <= delay; w++) begin
        @(negedge clock);
        chk1("ovalid_wait", ovalid, 1'b0);
        chk1("req_access", dmem_req, 1'b1);
        chk1("we_access", dmem_we, t.memWrite);
        chk32("addr_access", dmem_addr, t.result);
        chk32("wdata_access", dmem_wdata, t.b);
        ack        = (w == delay);
        dmem_ack   = ack;
        dmem_rdata = ack ? rdata : $urandom;
        #1;
        chk1("stall_access", stall, ~ack);
        chk1("redirect_access", redirect, ack & xfer);
        if (stall) stallCount++;
      end
    end

    @(negedge clock);
    dmem_ack = 1'b0;
    chk32("stall_cycles", stallCount, isAccess ? 32'(delay + 1) : 32'd0);
    chk1("ovalid", ovalid, t.valid);
    chk1("addrerr", oAddrErr, isMem & isMis);
    chk32("readdata", oReadData, expRd);
    chk32("result", oResult, t.result);
    chk32("instr", oInstr, t.instr);
    chk32("pc", oPC, t.pc);
    chk32("wreg", 32'(owriteRegWire), 32'(t.wr));
    chk1("memtoreg", oMemToReg, t.memToReg);
    if (t.valid) chk1("regwrite", oRegWrite, t.regWrite & ~(isMem & isMis));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    instT t;
    reset      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    t = randInst(0);
    t.valid = 1'b0;
    drive(t);
    repeat (2) @(negedge clock);

    // Reset values
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_we", dmem_we, 1'b0);
    chk32("rst_addr", dmem_addr, 32'd0);
    chk32("rst_wdata", dmem_wdata, 32'd0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_ovalid", ovalid, 1'b0);
    chk1("rst_addrerr", oAddrErr, 1'b0);
    chk1("rst_regwrite", oRegWrite, 1'b0);
    chk1("rst_memtoreg", oMemToReg, 1'b0);
    chk32("rst_readdata", oReadData, 32'd0);
    chk32("rst_result", oResult, 32'd0);
    chk32("rst_instr", oInstr, 32'd0);
    chk32("rst_pc", oPC, 32'd0);
    chk32("rst_wreg", 32'(owriteRegWire), 32'd0);
    reset = 1'b1;

    // ALU op retires next edge with no stall
    t = randInst(1);
    t.result = 32'h0000_0010; t.regWrite = 1'b1;
    runInstr(t, 0, 32'd0, 1'b0);

    // Load with ack three cycles after the request
    t = randInst(2);
    t.result = 32'h0000_0100; t.regWrite = 1'b1;
    runInstr(t, 3, 32'hDEAD_BEEF, 1'b0);

    // Store, fields held over two wait cycles
    t = randInst(3);
    t.result = 32'h0000_0204; t.b = 32'h0000_1234;
    runInstr(t, 2, 32'hFFFF_FFFF, 1'b0);

    // Misaligned load
    t = randInst(4);
    t.result = 32'h0000_0102; t.memRead = 1'b1; t.memWrite = 1'b0; t.regWrite = 1'b1;
    runInstr(t, 0, 32'd0, 1'b0);

    // beq taken / bne-style not taken
    t = randInst(1);
    t.branch = 1'b1; t.zero = 1'b1; t.inv = 1'b0; t.jump = 1'b0; t.tgt = 32'h0000_0040;
    runInstr(t, 0, 32'd0, 1'b0);
    t.inv = 1'b1;
    runInstr(t, 0, 32'd0, 1'b0);

    // Jump wins over a taken branch
    t = randInst(1);
    t.branch = 1'b1; t.zero = 1'b0; t.inv = 1'b1; t.jump = 1'b1;
    runInstr(t, 0, 32'd0, 1'b0);

    // Stray ack while idle, on an ALU op and on the first cycle of a load
    runInstr(randInst(1), 0, 32'd0, 1'b1);
    runInstr(randInst(2), 1, 32'hA5A5_5A5A, 1'b1);

    // Reset in the middle of an access, ack arriving in and after the reset cycle
    t = randInst(2);
    drive(t);
    @(negedge clock);
    chk1("mid_req_before", dmem_req, 1'b1);
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    @(negedge clock);
    chk1("mid_req_after", dmem_req, 1'b0);
    chk1("mid_ovalid", ovalid, 1'b0);
    chk32("mid_addr", dmem_addr, 32'd0);
    chk32("mid_readdata", oReadData, 32'd0);
    reset = 1'b1;
    t.valid = 1'b0;
    drive(t);
    @(negedge clock);
    chk1("post_req", dmem_req, 1'b0);
    chk1("post_ovalid", ovalid, 1'b0);
    chk1("post_stall", stall, 1'b0);
    dmem_ack = 1'b0;

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      runInstr(randInst($urandom_range(0, 4)), $urandom_range(0, 3), $urandom,
               1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low; reset==0 sampled at a rising edge resets the block.
REQ-003 iInstr, iPC, iNPC1, inextPCBranch  in  32 each  instruction, its PC, PC+4, branch target from the EX/MEM register.
REQ-004 iRegWrite, iMemRead, iMemWrite, iMemToReg, iBranch, iinvertzero, iJump, iZero  in  1 each  control bits and ALU zero flag from EX/MEM.
REQ-005 iResult, iB  in  32 each  ALU result (memory address) and store data.
REQ-006 iwriteRegWire  in  5  destination register; ivalid  in  1  EX/MEM entry holds a real instruction.
REQ-007 dmem_req, dmem_we  out  1 each  data-memory request, write enable.
REQ-008 dmem_addr, dmem_wdata  out  32 each  word address and store data.
REQ-009 dmem_rdata  in  32; dmem_ack  in  1  read data and one-cycle completion pulse.
REQ-010 stall  out  1  freeze request to all upstream pipeline registers (drives their enable low).
REQ-011 redirect  out  1; oTargetPC  out  32  taken control transfer and its target.
REQ-012 oRegWrite, oMemToReg, ovalid, oAddrErr  out  1 each  MEM/WB control and status.
REQ-013 oReadData, oResult, oInstr, oPC  out  32 each; owriteRegWire  out  5  MEM/WB data.

Function
REQ-014 Memory op defined as mem_op = ivalid & (iMemRead | iMemWrite); misaligned defined as iResult[1:0] != 0.
REQ-015 FSM states IDLE, ACCESS; reset state IDLE.
REQ-016 IDLE, mem_op and aligned: stall=1 combinationally; next edge latches address, store data, we=iMemWrite, and all pass-through fields; goes to ACCESS.
REQ-017 ACCESS: dmem_req=1; dmem_addr, dmem_wdata, dmem_we driven from latched copies, stable until ack.
REQ-018 ACCESS, dmem_ack=0: stall=1; MEM/WB registers load a bubble (ovalid=0, oRegWrite=0).
REQ-019 ACCESS, dmem_ack=1: stall=0 same cycle; that edge loads oReadData=dmem_rdata (0 for stores) plus latched fields, ovalid=1; returns to IDLE.
REQ-020 Minimum memory-op latency: 2 cycles from ivalid to ovalid (ack in first ACCESS cycle); each extra wait cycle adds one.
REQ-021 IDLE, non-memory or ivalid=0: stall=0; MEM/WB registers load the inputs directly next edge (latency 1), ovalid=ivalid, oReadData=0.
REQ-022 Misaligned mem_op: no request issued, stall=0, latency 1; MEM/WB loads ovalid=1, oAddrErr=1, oRegWrite=0.
REQ-023 oAddrErr=0 for every other instruction.
REQ-024 redirect = ivalid & !stall & ((iBranch & (iZero ^ iinvertzero)) | iJump), combinational.
REQ-025 oTargetPC = iJump ? {iNPC1[31:28], iInstr[25:0], 2'b00} : inextPCBranch; iJump has priority when both set.
REQ-026 dmem_ack while IDLE shall be ignored; dmem_req=0 in IDLE.
REQ-027 dmem_wdata = latched iB unmodified; word accesses only, no byte lanes.

Reset
REQ-028 On reset: FSM=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, stall=0.
REQ-029 On reset: all MEM/WB outputs 0, including ovalid and oAddrErr.
REQ-030 Reset during ACCESS abandons the access; ack arriving in the reset cycle or after is ignored; no ovalid results.

Verification
REQ-031 ALU op, ivalid=1, iResult=0x0000_0010, iRegWrite=1 -> next edge ovalid=1, oResult=0x10, stall never 1.
REQ-032 Load iResult=0x100, ack 3 cycles after request, rdata=0xDEADBEEF -> stall high 4 cycles, one ovalid pulse with oReadData=0xDEADBEEF.
REQ-033 Store iResult=0x204, iB=0x1234 -> dmem_we=1, addr=0x204, wdata=0x1234 held until ack; oRegWrite=0.
REQ-034 Load iResult=0x102 -> no dmem_req, oAddrErr=1, oRegWrite=0, ovalid=1 next edge.
REQ-035 beq-style iBranch=1, iZero=1, iinvertzero=0, inextPCBranch=0x40 -> redirect=1, oTargetPC=0x40; with iinvertzero=1 -> redirect=0.
REQ-036 reset=0 driven mid-ACCESS, then ack -> dmem_req=0 after edge, ovalid stays 0, FSM IDLE.
